// File: rtl/car_park_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : car_park_ctrl
// Purpose  : Parking-lot controller with separate entry/exit lanes, per-space
//            occupancy and timestamps, duration-based fee and timed barriers.
// Revision : 1.0
// ============================================================================
module car_park_ctrl #(
    parameter int NUM_SPACES = 5,
    parameter int ID_W       = 3,
    parameter int TICK_DIV   = 1000,
    parameter int TIME_W     = 16,
    parameter int RATE       = 2,
    parameter int FEE_W      = 16,
    parameter int BAR_CYCLES = 5000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sout,
    input  logic [ID_W-1:0]  exit_ticket,
    input  logic             pay,
    output logic             bin,
    output logic             bout,
    output logic [ID_W-1:0]  entry_ticket,
    output logic             entry_valid,
    output logic [FEE_W-1:0] fee,
    output logic             fee_valid,
    output logic [ID_W:0]    free_spaces,
    output logic             full,
    output logic             err_ticket
);

    localparam int c_pre_w  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_bar_w  = (BAR_CYCLES > 1) ? $clog2(BAR_CYCLES) : 1;
    localparam int c_prod_w = TIME_W + FEE_W + 33;
    localparam logic [c_pre_w-1:0]  c_pre_last = c_pre_w'(TICK_DIV - 1);
    localparam logic [c_bar_w-1:0]  c_bar_last = c_bar_w'(BAR_CYCLES - 1);
    localparam logic [c_prod_w-1:0] c_fee_max  = {{(c_prod_w-FEE_W){1'b0}}, {FEE_W{1'b1}}};
    localparam logic [ID_W:0]       c_num      = (ID_W+1)'(NUM_SPACES);

    typedef enum logic [1:0] {EN_IDLE = 2'd0, EN_WAIT_SPACE = 2'd1, EN_OPEN = 2'd2} en_state_t;
    typedef enum logic [1:0] {EX_IDLE = 2'd0, EX_CALC = 2'd1, EX_WAIT_PAY = 2'd2, EX_OPEN = 2'd3} ex_state_t;

    en_state_t              r_en_state, w_en_next;
    ex_state_t              r_ex_state, w_ex_next;
    logic [c_pre_w-1:0]     r_presc;
    logic [TIME_W-1:0]      r_time;
    logic [c_bar_w-1:0]     r_en_bar, r_ex_bar;
    logic [NUM_SPACES-1:0]  r_occ;
    logic [TIME_W-1:0]      r_ts [NUM_SPACES];
    logic [ID_W:0]          r_free;
    logic                   r_full;
    logic [ID_W-1:0]        r_entry_ticket, r_t;
    logic                   r_entry_valid, r_err;
    logic [FEE_W-1:0]       r_fee;

    logic                   w_alloc, w_rel, w_latch, w_err, w_exit_ok;
    logic [ID_W-1:0]        w_alloc_idx;
    logic [2**ID_W-1:0]     w_occ_ext;
    logic [TIME_W-1:0]      w_ts_sel, w_elapsed;
    logic [c_prod_w-1:0]    w_prod;
    logic [FEE_W-1:0]       w_fee_sat;

    // Lowest-index free space, taken from the bitmap as it stood before this cycle
    always_comb begin
        w_alloc_idx = '0;
        for (int i = NUM_SPACES - 1; i >= 0; i--) begin
            if (!r_occ[i]) w_alloc_idx = ID_W'(i);
        end
    end

    // Padding lets any presented ticket index the bitmap safely
    assign w_occ_ext = (2**ID_W)'(r_occ);
    assign w_exit_ok = ({1'b0, exit_ticket} < c_num) && w_occ_ext[exit_ticket];

    always_comb begin
        w_ts_sel = '0;
        for (int i = 0; i < NUM_SPACES; i++) begin
            if (r_t == ID_W'(i)) w_ts_sel = r_ts[i];
        end
    end

    assign w_elapsed = r_time - w_ts_sel;
    assign w_prod    = (c_prod_w'(w_elapsed) + c_prod_w'(1)) * c_prod_w'(RATE);
    assign w_fee_sat = (w_prod > c_fee_max) ? {FEE_W{1'b1}} : w_prod[FEE_W-1:0];

    always_comb begin
        w_en_next = r_en_state;
        w_alloc   = 1'b0;
        case (r_en_state)
            EN_IDLE: begin
                if (sin) begin
                    if (!r_full) begin
                        w_alloc   = 1'b1;
                        w_en_next = EN_OPEN;
                    end else begin
                        w_en_next = EN_WAIT_SPACE;
                    end
                end
            end
            EN_WAIT_SPACE: begin
                if (!sin) begin
                    w_en_next = EN_IDLE;
                end else if (!r_full) begin
                    w_alloc   = 1'b1;
                    w_en_next = EN_OPEN;
                end
            end
            EN_OPEN: begin
                if (r_en_bar == c_bar_last) w_en_next = EN_IDLE;
            end
            default: w_en_next = EN_IDLE;
        endcase
    end

    always_comb begin
        w_ex_next = r_ex_state;
        w_latch   = 1'b0;
        w_err     = 1'b0;
        w_rel     = 1'b0;
        case (r_ex_state)
            EX_IDLE: begin
                if (sout) begin
                    if (w_exit_ok) begin
                        w_latch   = 1'b1;
                        w_ex_next = EX_CALC;
                    end else begin
                        w_err     = 1'b1;
                    end
                end
            end
            EX_CALC:     w_ex_next = EX_WAIT_PAY;
            EX_WAIT_PAY: begin
                if (pay) begin
                    w_rel     = 1'b1;
                    w_ex_next = EX_OPEN;
                end
            end
            EX_OPEN: begin
                if (r_ex_bar == c_bar_last) w_ex_next = EX_IDLE;
            end
            default: w_ex_next = EX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en_state <= EN_IDLE;
            r_ex_state <= EX_IDLE;
        end else begin
            r_en_state <= w_en_next;
            r_ex_state <= w_ex_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc        <= '0;
            r_time         <= '0;
            r_en_bar       <= '0;
            r_ex_bar       <= '0;
            r_occ          <= '0;
            for (int i = 0; i < NUM_SPACES; i++) r_ts[i] <= '0;
            r_free         <= c_num;
            r_full         <= 1'b0;
            r_entry_ticket <= '0;
            r_entry_valid  <= 1'b0;
            r_t            <= '0;
            r_fee          <= '0;
            r_err          <= 1'b0;
        end else begin
            if (r_presc == c_pre_last) begin
                r_presc <= '0;
                r_time  <= r_time + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            r_en_bar <= (r_en_state == EN_OPEN && r_en_bar != c_bar_last) ? r_en_bar + 1'b1 : '0;
            r_ex_bar <= (r_ex_state == EX_OPEN && r_ex_bar != c_bar_last) ? r_ex_bar + 1'b1 : '0;
            // Allocation and release can never hit the same space in one cycle
            for (int i = 0; i < NUM_SPACES; i++) begin
                if (w_alloc && w_alloc_idx == ID_W'(i)) begin
                    r_occ[i] <= 1'b1;
                    r_ts[i]  <= r_time;
                end
                if (w_rel && r_t == ID_W'(i)) r_occ[i] <= 1'b0;
            end
            case ({w_alloc, w_rel})
                2'b10: begin
                    r_free <= r_free - 1'b1;
                    r_full <= (r_free == (ID_W+1)'(1));
                end
                2'b01: begin
                    r_free <= r_free + 1'b1;
                    r_full <= 1'b0;
                end
                default: ;
            endcase
            r_entry_valid <= w_alloc;
            if (w_alloc) r_entry_ticket <= w_alloc_idx;
            if (w_latch) r_t <= exit_ticket;
            if (r_ex_state == EX_CALC) r_fee <= w_fee_sat;
            r_err <= w_err;
        end
    end

    assign bin          = (r_en_state == EN_OPEN);
    assign bout         = (r_ex_state == EX_OPEN);
    assign entry_ticket = r_entry_ticket;
    assign entry_valid  = r_entry_valid;
    assign fee          = r_fee;
    assign fee_valid    = (r_ex_state == EX_WAIT_PAY);
    assign free_spaces  = r_free;
    assign full         = r_full;
    assign err_ticket   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_car_park_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_car_park_ctrl
// Purpose  : Directed table-driven bench for car_park_ctrl (2 spaces, 4-bit time).
// Revision : 1.0
// ============================================================================
module tb_car_park_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sin = 1'b0, sout = 1'b0, pay = 1'b0;
    logic [0:0]  exit_ticket = 1'b0;
    logic        bin, bout, entry_valid, fee_valid, full, err_ticket;
    logic [0:0]  entry_ticket;
    logic [15:0] fee;
    logic [1:0]  free_spaces;

    int n_checks = 0;
    int n_fail   = 0;

    car_park_ctrl #(
        .NUM_SPACES(2), .ID_W(1), .TICK_DIV(4), .TIME_W(4),
        .RATE(2), .FEE_W(16), .BAR_CYCLES(3)
    ) dut (
        .clk(clk), .rst(rst), .sin(sin), .sout(sout), .exit_ticket(exit_ticket),
        .pay(pay), .bin(bin), .bout(bout), .entry_ticket(entry_ticket),
        .entry_valid(entry_valid), .fee(fee), .fee_valid(fee_valid),
        .free_spaces(free_spaces), .full(full), .err_ticket(err_ticket)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sin, sout, et, pay;
        int          rep;
        logic        bin, bout, ev, eticket, fv;
        logic [15:0] fee;
        logic [1:0]  free;
        logic        full, err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic a_sin, a_sout, a_et, a_pay, input int a_rep,
                       input logic e_bin, e_bout, e_ev, e_et, e_fv, input logic [15:0] e_fee,
                       input logic [1:0] e_free, input logic e_full, e_err);
        vec_t v;
        v.sin = a_sin; v.sout = a_sout; v.et = a_et; v.pay = a_pay; v.rep = a_rep;
        v.bin = e_bin; v.bout = e_bout; v.ev = e_ev; v.eticket = e_et; v.fv = e_fv;
        v.fee = e_fee; v.free = e_free; v.full = e_full; v.err = e_err;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] act, exp;
        int vi;

        // time-dependent rows: entries at t=0,1,3,5,14,20; fees at t=2,4,9,18(wrap),20
        add(1,0,0,0,1,  1,0,1,0,0,0,  2'd1,0,0);
        add(0,0,0,0,1,  1,0,0,0,0,0,  2'd1,0,0);
        add(0,1,1,0,1,  1,0,0,0,0,0,  2'd1,0,1);
        add(0,0,0,0,1,  0,0,0,0,0,0,  2'd1,0,0);
        add(1,0,0,0,1,  1,0,1,1,0,0,  2'd0,1,0);
        add(0,0,0,0,2,  1,0,0,0,0,0,  2'd0,1,0);
        add(1,0,0,0,2,  0,0,0,0,0,0,  2'd0,1,0);
        add(1,1,1,0,1,  0,0,0,0,0,0,  2'd0,1,0);
        add(1,0,0,0,1,  0,0,0,0,1,4,  2'd0,1,0);
        add(1,0,0,1,1,  0,1,0,0,0,0,  2'd1,0,0);
        add(1,0,0,0,1,  1,1,1,1,0,0,  2'd0,1,0);
        add(0,0,0,0,1,  1,1,0,0,0,0,  2'd0,1,0);
        add(0,0,0,0,1,  1,0,0,0,0,0,  2'd0,1,0);
        add(0,0,0,0,1,  0,0,0,0,0,0,  2'd0,1,0);
        add(0,1,0,0,1,  0,0,0,0,0,0,  2'd0,1,0);
        add(0,0,0,0,2,  0,0,0,0,1,10, 2'd0,1,0);
        add(0,0,0,1,1,  0,1,0,0,0,0,  2'd1,0,0);
        add(0,0,0,0,1,  0,1,0,0,0,0,  2'd1,0,0);
        add(1,0,0,0,1,  1,1,1,0,0,0,  2'd0,1,0);
        add(0,0,0,0,2,  1,0,0,0,0,0,  2'd0,1,0);
        add(0,0,0,0,12, 0,0,0,0,0,0,  2'd0,1,0);
        add(0,1,0,0,1,  0,0,0,0,0,0,  2'd0,1,0);
        add(0,0,0,0,2,  0,0,0,0,1,10, 2'd0,1,0);
        add(0,0,0,1,1,  0,1,0,0,0,0,  2'd1,0,0);
        add(0,0,0,0,2,  0,1,0,0,0,0,  2'd1,0,0);
        add(0,0,0,0,1,  0,0,0,0,0,0,  2'd1,0,0);
        add(0,1,0,0,1,  0,0,0,0,0,0,  2'd1,0,1);
        add(0,0,0,0,13, 0,0,0,0,0,0,  2'd1,0,0);
        add(1,0,0,0,1,  1,0,1,0,0,0,  2'd0,1,0);
        add(0,0,0,0,2,  1,0,0,0,0,0,  2'd0,1,0);
        add(0,0,0,0,12, 0,0,0,0,0,0,  2'd0,1,0);
        add(0,1,0,0,1,  0,0,0,0,0,0,  2'd0,1,0);
        add(0,0,0,0,2,  0,0,0,0,1,10, 2'd0,1,0);
        add(0,0,0,1,1,  0,1,0,0,0,0,  2'd1,0,0);
        add(0,0,0,0,2,  0,1,0,0,0,0,  2'd1,0,0);
        add(0,0,0,0,1,  0,0,0,0,0,0,  2'd1,0,0);
        add(0,1,1,0,1,  0,0,0,0,0,0,  2'd1,0,0);
        add(1,0,0,0,1,  1,0,1,0,1,4,  2'd0,1,0);

        repeat (2) @(negedge clk);
        check("reset bin",         32'(bin),          32'd0);
        check("reset bout",        32'(bout),         32'd0);
        check("reset entry_valid", 32'(entry_valid),  32'd0);
        check("reset entry_ticket",32'(entry_ticket), 32'd0);
        check("reset fee_valid",   32'(fee_valid),    32'd0);
        check("reset fee",         32'(fee),          32'd0);
        check("reset free_spaces", 32'(free_spaces),  32'd2);
        check("reset full",        32'(full),         32'd0);
        check("reset err_ticket",  32'(err_ticket),   32'd0);

        rst = 1'b1;
        vi = 0;
        foreach (vecs[r]) begin
            for (int k = 0; k < vecs[r].rep; k++) begin
                sin = vecs[r].sin; sout = vecs[r].sout;
                exit_ticket = vecs[r].et; pay = vecs[r].pay;
                @(negedge clk);
                act = {7'd0, bin, bout, entry_valid, (vecs[r].ev ? entry_ticket : 1'b0),
                       fee_valid, (vecs[r].fv ? fee : 16'h0), free_spaces, full, err_ticket};
                exp = {7'd0, vecs[r].bin, vecs[r].bout, vecs[r].ev, vecs[r].eticket,
                       vecs[r].fv, vecs[r].fee, vecs[r].free, vecs[r].full, vecs[r].err};
                check($sformatf("vec%0d", vi), act, exp);
                vi++;
            end
        end

        // Asynchronous reset with entry barrier open and exit waiting for payment
        sin = 1'b0; sout = 1'b0; pay = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("async bin",         32'(bin),         32'd0);
        check("async bout",        32'(bout),        32'd0);
        check("async fee_valid",   32'(fee_valid),   32'd0);
        check("async entry_valid", 32'(entry_valid), 32'd0);
        check("async free_spaces", 32'(free_spaces), 32'd2);
        check("async full",        32'(full),        32'd0);

        @(negedge clk);
        rst = 1'b1;
        sout = 1'b1; exit_ticket = 1'b0;
        @(negedge clk);
        sout = 1'b0;
        check("post-reset err",       32'(err_ticket), 32'd1);
        check("post-reset fee_valid", 32'(fee_valid),  32'd0);
        check("post-reset bout",      32'(bout),       32'd0);
        @(negedge clk);
        check("post-reset err clear", 32'(err_ticket), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
